// File: rtl/k7_aurora_pkg.sv
// Shared types and sizing helpers for the Kintex-7 Aurora bring-up sequencer.
package k7_aurora_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PMA     = 3'd1,
    ST_PB      = 3'd2,
    ST_WAIT_UP = 3'd3,
    ST_UP      = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  // One counter serves every phase, so it must hold the largest terminal count.
  function automatic int cnt_width(input int pma_dly, input int pb_dly,
                                   input int up_timeout, input int drop_filt);
    int m;
    m = pma_dly;
    if (pb_dly > m) m = pb_dly;
    if (up_timeout > m) m = up_timeout;
    if (drop_filt > m) m = drop_filt;
    return $clog2(m + 1);
  endfunction

  function automatic int retry_width(input int max_retry);
    int w;
    w = $clog2(max_retry + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/aurora_boot_ch.sv
// One Aurora channel: CHANNEL_UP synchroniser, bring-up FSM, phase counter and retry counter.
module aurora_boot_ch
  import k7_aurora_pkg::*;
#(
  parameter int PMA_DLY    = 100,
  parameter int PB_DLY     = 100,
  parameter int UP_TIMEOUT = 50000,
  parameter int DROP_FILT  = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   lock_i,
  input  logic   chan_up_i,
  input  logic   reinit_i,
  output logic   pma_init_o,
  output logic   reset_pb_o,
  output logic   link_ok_o,
  output logic   fail_o,
  output state_e state_o
);

  localparam int CW = cnt_width(PMA_DLY, PB_DLY, UP_TIMEOUT, DROP_FILT);
  localparam int RW = retry_width(MAX_RETRY);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] PMA_LAST   = CW'(PMA_DLY - 1);
  localparam logic [CW-1:0] PB_LAST    = CW'(PB_DLY - 1);
  localparam logic [CW-1:0] UP_LAST    = CW'(UP_TIMEOUT - 1);
  localparam logic [CW-1:0] DROP_LAST  = CW'(DROP_FILT - 1);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pma_q, pma_d, pb_q, pb_d, link_q, link_d, fail_q, fail_d;
  logic            up_m_q, up_s_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    retry_d = retry_q;
    pma_d   = pma_q;
    pb_d    = pb_q;
    link_d  = link_q;
    fail_d  = fail_q;
    if (!lock_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      retry_d = '0;
      pma_d   = 1'b1;
      pb_d    = 1'b1;
      link_d  = 1'b0;
      fail_d  = 1'b0;
    end else if (reinit_i && state_q != ST_IDLE) begin
      state_d = ST_PMA;
      cnt_d   = '0;
      retry_d = '0;
      pma_d   = 1'b1;
      pb_d    = 1'b1;
      link_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_PMA;
          cnt_d   = '0;
          pma_d   = 1'b1;
          pb_d    = 1'b1;
        end
        ST_PMA: if (cnt_q == PMA_LAST) begin
          state_d = ST_PB;
          cnt_d   = '0;
          pma_d   = 1'b0;
        end
        ST_PB: if (cnt_q == PB_LAST) begin
          state_d = ST_WAIT_UP;
          cnt_d   = '0;
          pb_d    = 1'b0;
        end
        // A link coming up on the timeout cycle wins over the retry.
        ST_WAIT_UP: if (up_s_q) begin
          state_d = ST_UP;
          cnt_d   = '0;
          link_d  = 1'b1;
        end else if (cnt_q == UP_LAST) begin
          cnt_d = '0;
          pma_d = 1'b1;
          pb_d  = 1'b1;
          if (retry_q == RETRY_LAST) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_PMA;
            retry_d = retry_q + RETRY_ONE;
          end
        end
        // cnt is the run length of consecutive low UP_S samples.
        ST_UP: if (up_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == DROP_LAST) begin
          state_d = ST_PMA;
          cnt_d   = '0;
          retry_d = '0;
          link_d  = 1'b0;
          pma_d   = 1'b1;
          pb_d    = 1'b1;
        end
        ST_FAIL: cnt_d = '0;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          retry_d = '0;
          pma_d   = 1'b1;
          pb_d    = 1'b1;
          link_d  = 1'b0;
          fail_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      pma_q   <= 1'b1;
      pb_q    <= 1'b1;
      link_q  <= 1'b0;
      fail_q  <= 1'b0;
      up_m_q  <= 1'b0;
      up_s_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pma_q   <= pma_d;
      pb_q    <= pb_d;
      link_q  <= link_d;
      fail_q  <= fail_d;
      up_m_q  <= chan_up_i;
      up_s_q  <= up_m_q;
    end
  end

  assign pma_init_o = pma_q;
  assign reset_pb_o = pb_q;
  assign link_ok_o  = link_q;
  assign fail_o     = fail_q;
  assign state_o    = state_q;

endmodule

// File: rtl/k7_aurora_boot_seq.sv
// Multi-channel Aurora 64b66b bring-up sequencer; one independent supervisor per channel.
module k7_aurora_boot_seq
  import k7_aurora_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PMA_DLY    = 100,
  parameter int PB_DLY     = 100,
  parameter int UP_TIMEOUT = 50000,
  parameter int DROP_FILT  = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DCM_LOCKED,
  input  logic [N_CH-1:0]   CHANNEL_UP,
  input  logic [N_CH-1:0]   REINIT,
  output logic [N_CH-1:0]   PMA_INIT,
  output logic [N_CH-1:0]   RESET_PB,
  output logic [N_CH-1:0]   LINK_OK,
  output logic [N_CH-1:0]   FAIL,
  output logic [3*N_CH-1:0] DBG_STATE
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e ch_state;

    aurora_boot_ch #(
      .PMA_DLY    (PMA_DLY),
      .PB_DLY     (PB_DLY),
      .UP_TIMEOUT (UP_TIMEOUT),
      .DROP_FILT  (DROP_FILT),
      .MAX_RETRY  (MAX_RETRY)
    ) u_ch (
      .clk_i      (CLK),
      .rst_i      (RST),
      .lock_i     (DCM_LOCKED),
      .chan_up_i  (CHANNEL_UP[g]),
      .reinit_i   (REINIT[g]),
      .pma_init_o (PMA_INIT[g]),
      .reset_pb_o (RESET_PB[g]),
      .link_ok_o  (LINK_OK[g]),
      .fail_o     (FAIL[g]),
      .state_o    (ch_state)
    );

    assign DBG_STATE[3*g +: 3] = ch_state;
  end

endmodule
